seg_scan_driver: RTL

Multiplexed six-digit 7-segment display driver that consumes the lock controller's six 4-bit digit outputs (BCD 0-9, 4'b1110 = error 'E').
- Scans one digit per slot, with an anti-ghosting blank interval at the start of each slot.
- Snapshots all six digits once per frame so the display never tears.
- Supports per-digit enable and per-digit blink, used for LED/error signalling.

---
 rtl/seg_scan_driver.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Six-digit multiplexed 7-segment scan driver with per-frame
//                digit snapshot, anti-ghosting blank, per-digit enable/blink.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_DIV    = 50
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [3:0] d6,
    input  logic [5:0] digit_en,
    input  logic [5:0] blink,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam logic [15:0] C_CYC_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] C_BLANK     = 16'(BLANK_CYCLES);
    localparam logic [7:0]  C_FRM_LAST  = 8'(BLINK_DIV - 1);
    localparam logic [2:0]  C_SLOT_LAST = 3'd5;

    logic             run_q,   run_d;
    logic [15:0]      cyc_q,   cyc_d;
    logic [2:0]       slot_q,  slot_d;
    logic [7:0]       frame_q, frame_d;
    logic             phase_q, phase_d;
    logic [5:0][3:0]  snap_q,  snap_d;
    logic [5:0]       en_q,    en_d;
    logic [5:0]       blk_q,   blk_d;
    logic [6:0]       seg_q,   seg_d;
    logic [5:0]       an_q,    an_d;
    logic             tick_q,  tick_d;
    logic             w_new_frame;
    logic             w_lit;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hE:    s = 7'b1001111;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    always_comb begin
        run_d   = 1'b1;
        cyc_d   = cyc_q;
        slot_d  = slot_q;
        frame_d = frame_q;
        phase_d = phase_q;
        snap_d  = snap_q;
        en_d    = en_q;
        blk_d   = blk_q;
        // The first edge after reset enters slot 0, cycle 0 without advancing.
        w_new_frame = !run_q || (cyc_q == C_CYC_LAST && slot_q == C_SLOT_LAST);
        if (!run_q) begin
            cyc_d  = 16'd0;
            slot_d = 3'd0;
        end else if (cyc_q == C_CYC_LAST) begin
            cyc_d = 16'd0;
            if (slot_q == C_SLOT_LAST) begin
                slot_d = 3'd0;
                if (frame_q == C_FRM_LAST) begin
                    frame_d = 8'd0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + 8'd1;
                end
            end else begin
                slot_d = slot_q + 3'd1;
            end
        end else begin
            cyc_d = cyc_q + 16'd1;
        end

        if (w_new_frame) begin
            snap_d = {d6, d5, d4, d3, d2, d1};
            en_d   = digit_en;
            blk_d  = blink;
        end

        // Outputs are computed from the position being entered, so they
        // line up with the counters on the same edge.
        w_lit  = (cyc_d >= C_BLANK) && en_d[slot_d] && !(blk_d[slot_d] && phase_d);
        an_d   = w_lit ? ~(6'b000001 << slot_d) : 6'b111111;
        seg_d  = w_lit ? decode(snap_d[slot_d]) : 7'b0000000;
        tick_d = (slot_d == C_SLOT_LAST) && (cyc_d == C_CYC_LAST);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            run_q   <= 1'b0;
            cyc_q   <= 16'd0;
            slot_q  <= 3'd0;
            frame_q <= 8'd0;
            phase_q <= 1'b0;
            snap_q  <= '0;
            en_q    <= 6'd0;
            blk_q   <= 6'd0;
            seg_q   <= 7'b0000000;
            an_q    <= 6'b111111;
            tick_q  <= 1'b0;
        end else begin
            run_q   <= run_d;
            cyc_q   <= cyc_d;
            slot_q  <= slot_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            en_q    <= en_d;
            blk_q   <= blk_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

`default_nettype wire
